// File: rtl/dcache_ctrl_if.sv
// Bus bundle between the data-cache controller, the MEM stage, the cache SRAM and data memory.
// Signal suffixes are from the controller's point of view; master = controller, slave = environment.
interface dcache_ctrl_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned SET_W  = 4;
  localparam int unsigned TAGW_W = 25;

  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [WORD_W-1:0] cpu_data_i;
  logic [WORD_W-1:0] cpu_data_o;
  logic              cpu_stall_o;

  logic              sram_enable_o;
  logic              sram_write_o;
  logic [SET_W-1:0]  sram_addr_o;
  logic [TAGW_W-1:0] sram_tag_o;
  logic [LINE_W-1:0] sram_data_o;
  logic [TAGW_W-1:0] sram_tag_i;
  logic [LINE_W-1:0] sram_data_i;
  logic              sram_hit_i;

  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport master (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    output cpu_data_o, cpu_stall_o,
    output sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o,
    input  sram_tag_i, sram_data_i, sram_hit_i,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    input  cpu_data_o, cpu_stall_o,
    input  sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o,
    output sram_tag_i, sram_data_i, sram_hit_i,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/dcache_ctrl.sv
// 2-way data-cache controller: combinational hits, write-back/refill sequencing on misses.
// Optional hit/miss counters enabled by defining DCACHE_PERF_CNT_EN.
module dcache_ctrl (
  input  logic          clk_i,
  input  logic          rst_i,
  dcache_ctrl_if.master bus
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]   hit_cnt_o,
  output logic [31:0]   miss_cnt_o
`endif
);
  localparam int unsigned TAG_W   = 23;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned LINE_W  = 256;
  localparam int unsigned TAGW_W  = 25;

  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, UPDATE} state_e;

  state_e              state_q, state_d;
  logic [TAGW_W-1:0]   victim_tag_q;
  logic [LINE_W-1:0]   victim_data_q;
  logic [LINE_W-1:0]   refill_data_q;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [SEL_W-1:0]    req_sel;
  logic                idle_hit_c;
  logic                idle_miss_c;
  logic                unused_addr_lsb;

  assign req_tag         = bus.cpu_addr_i[31:9];
  assign req_idx         = bus.cpu_addr_i[8:5];
  assign req_sel         = bus.cpu_addr_i[4:2];
  assign unused_addr_lsb = ^bus.cpu_addr_i[1:0];

  assign idle_hit_c  = !rst_i && (state_q == IDLE) && bus.cpu_req_i &&  bus.sram_hit_i;
  assign idle_miss_c = !rst_i && (state_q == IDLE) && bus.cpu_req_i && !bus.sram_hit_i;

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [SEL_W-1:0]  sel,
                                                   input logic [WORD_W-1:0] word);
    logic [LINE_W-1:0] res;
    res = line;
    res[{sel, 5'd0} +: WORD_W] = word;
    return res;
  endfunction

  // State plus victim/refill line buffers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      victim_tag_q  <= '0;
      victim_data_q <= '0;
      refill_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (idle_miss_c) begin
        victim_tag_q  <= bus.sram_tag_i;
        victim_data_q <= bus.sram_data_i;
      end
      if ((state_q == REFILL) && bus.mem_ack_i) begin
        refill_data_q <= bus.mem_data_i;
      end
    end
  end

  // Next state and all bus outputs; everything held at zero while reset is asserted
  always_comb begin
    state_d           = state_q;
    bus.cpu_data_o    = '0;
    bus.cpu_stall_o   = 1'b0;
    bus.sram_enable_o = 1'b0;
    bus.sram_write_o  = 1'b0;
    bus.sram_addr_o   = '0;
    bus.sram_tag_o    = '0;
    bus.sram_data_o   = '0;
    bus.mem_enable_o  = 1'b0;
    bus.mem_write_o   = 1'b0;
    bus.mem_addr_o    = '0;
    bus.mem_data_o    = '0;

    if (rst_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.cpu_req_i) begin
            bus.sram_enable_o = 1'b1;
            bus.sram_addr_o   = req_idx;
            bus.sram_tag_o    = {2'b10, req_tag};
            if (bus.sram_hit_i) begin
              if (bus.cpu_we_i) begin
                bus.sram_write_o = 1'b1;
                bus.sram_tag_o   = {2'b11, req_tag};
                bus.sram_data_o  = merge_word(bus.sram_data_i, req_sel, bus.cpu_data_i);
              end else begin
                bus.cpu_data_o = bus.sram_data_i[{req_sel, 5'd0} +: WORD_W];
              end
            end else begin
              bus.cpu_stall_o = 1'b1;
              state_d         = MISS;
            end
          end
        end
        MISS: begin
          bus.cpu_stall_o = 1'b1;
          state_d = (victim_tag_q[24] && victim_tag_q[23]) ? WRITEBACK : REFILL;
        end
        WRITEBACK: begin
          bus.cpu_stall_o  = 1'b1;
          bus.mem_enable_o = 1'b1;
          bus.mem_write_o  = 1'b1;
          bus.mem_addr_o   = {victim_tag_q[TAG_W-1:0], req_idx, 5'd0};
          bus.mem_data_o   = victim_data_q;
          if (bus.mem_ack_i) state_d = REFILL;
        end
        REFILL: begin
          bus.cpu_stall_o  = 1'b1;
          bus.mem_enable_o = 1'b1;
          bus.mem_addr_o   = {req_tag, req_idx, 5'd0};
          if (bus.mem_ack_i) state_d = UPDATE;
        end
        UPDATE: begin
          bus.cpu_stall_o   = 1'b1;
          bus.sram_enable_o = 1'b1;
          bus.sram_write_o  = 1'b1;
          bus.sram_addr_o   = req_idx;
          bus.sram_tag_o    = {1'b1, bus.cpu_we_i, req_tag};
          bus.sram_data_o   = bus.cpu_we_i ? merge_word(refill_data_q, req_sel, bus.cpu_data_i)
                                           : refill_data_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic replay_q;

  // The first IDLE cycle after UPDATE is the held request replaying, not a new hit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      replay_q   <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      replay_q <= (state_q == UPDATE);
      if (idle_hit_c && !replay_q) hit_cnt_o  <= hit_cnt_o + 32'(1);
      if (idle_miss_c)             miss_cnt_o <= miss_cnt_o + 32'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a behavioural 2-way SRAM, a line memory and a load-data scoreboard.
module tb_dcache_ctrl;
  logic clk;
  logic rst;

  dcache_ctrl_if bus ();

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  dcache_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mreq_t;

  mreq_t        mem_log [$];
  logic [255:0] mem_m [logic [31:0]];
  logic [31:0]  ref_m [logic [31:0]];
  logic [31:0]  exp_q [$];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_F0F0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (ref_m.exists(a)) return ref_m[a];
    return init_word(a);
  endfunction

  function automatic logic [255:0] mem_read(input logic [31:0] a);
    logic [255:0] l;
    if (mem_m.exists(a)) return mem_m[a];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(a + 32'(w * 4));
    return l;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cache SRAM model: looked up by the held CPU address, written with the controller's outputs
  bit [24:0]   tag_m  [2][16];
  bit [255:0]  data_m [2][16];
  bit          lru_m  [16];
  logic        sm_h0, sm_h1, sm_way;
  logic [3:0]  sm_idx;
  logic [24:0] last_wr_tag;

  always_comb begin
    sm_idx = bus.cpu_addr_i[8:5];
    sm_h0  = tag_m[0][sm_idx][24] && (tag_m[0][sm_idx][22:0] == bus.cpu_addr_i[31:9]);
    sm_h1  = tag_m[1][sm_idx][24] && (tag_m[1][sm_idx][22:0] == bus.cpu_addr_i[31:9]);
    sm_way = sm_h0 ? 1'b0 : (sm_h1 ? 1'b1 : lru_m[sm_idx]);
    bus.sram_hit_i  = sm_h0 || sm_h1;
    bus.sram_tag_i  = tag_m[sm_way][sm_idx];
    bus.sram_data_i = data_m[sm_way][sm_idx];
  end

  always @(posedge clk) begin
    if (bus.sram_enable_o && bus.sram_write_o) begin
      tag_m[sm_way][bus.sram_addr_o]  <= bus.sram_tag_o;
      data_m[sm_way][bus.sram_addr_o] <= bus.sram_data_o;
      last_wr_tag                     <= bus.sram_tag_o;
    end
    if (bus.sram_enable_o && (bus.sram_write_o || bus.sram_hit_i))
      lru_m[bus.sram_addr_o] <= ~sm_way;
  end

  // Data memory: acks the ack_delay-th cycle of each request, or a hand-driven ack
  logic mem_auto = 1'b1;
  logic auto_ack = 1'b0;
  logic man_ack  = 1'b0;
  int   ack_delay = 3;
  int   mem_cnt   = 0;

  assign bus.mem_ack_i = mem_auto ? auto_ack : man_ack;

  always @(negedge clk) begin
    if (auto_ack) begin
      auto_ack = 1'b0;
      mem_cnt  = 0;
    end
    if (mem_auto && bus.mem_enable_o) begin
      mem_cnt++;
      bus.mem_data_i = mem_read(bus.mem_addr_o);
      if (mem_cnt == ack_delay) begin
        auto_ack = 1'b1;
        mem_log.push_back('{wr: bus.mem_write_o, addr: bus.mem_addr_o, data: bus.mem_data_o});
        if (bus.mem_write_o) mem_m[bus.mem_addr_o] = bus.mem_data_o;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  logic [24:0]  hit_tag;
  logic [255:0] hit_data;
  logic         hit_wr;
  int           stalls;
  int           base;

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        output int n_stall, output int log_base);
    logic [31:0] exp;
    bit          done;
    log_base = mem_log.size();
    @(posedge clk); #1;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = we;
    bus.cpu_addr_i = addr;
    bus.cpu_data_i = data;
    if (we) ref_m[addr] = data;
    else    exp_q.push_back(ref_word(addr));
    n_stall = 0;
    done    = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (bus.cpu_stall_o) n_stall++;
      else                 done = 1'b1;
    end
    check("access_completes", 32'(done), 32'd1);
    hit_tag  = bus.sram_tag_o;
    hit_data = bus.sram_data_o;
    hit_wr   = bus.sram_write_o;
    if (!we) begin
      exp = exp_q.pop_front();
      if (done) check("load_data", bus.cpu_data_o, exp);
    end
    @(posedge clk); #1;
    bus.cpu_req_i  = 1'b0;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h40;
    bus.cpu_data_i = '0;
    bus.mem_data_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall",       32'(bus.cpu_stall_o),   32'd0);
    check("rst_sram_enable", 32'(bus.sram_enable_o), 32'd0);
    check("rst_mem_enable",  32'(bus.mem_enable_o),  32'd0);
    check("rst_cpu_data",    bus.cpu_data_o,         32'd0);
    rst           = 1'b0;
    bus.cpu_req_i = 1'b0;

    // Cold load miss
    access(1'b0, 32'h40, 32'h0, stalls, base);
    check("cold_stalls", 32'(stalls), 32'd6);
    check("cold_nreq", 32'(mem_log.size() - base), 32'd1);
    if (mem_log.size() > base) begin
      check("cold_wr",   32'(mem_log[base].wr), 32'd0);
      check("cold_addr", mem_log[base].addr,    32'h40);
    end
    check("cold_update_tag", 32'(last_wr_tag), 32'h100_0000);

    // Store hit
    access(1'b1, 32'h44, 32'hDEAD_BEEF, stalls, base);
    check("st_hit_stalls", 32'(stalls), 32'd0);
    check("st_hit_write",  32'(hit_wr), 32'd1);
    check("st_hit_tag",    32'(hit_tag), 32'h180_0000);
    check("st_hit_word1",  hit_data[63:32], 32'hDEAD_BEEF);
    check("st_hit_word0",  hit_data[31:0],  init_word(32'h40));

    // Clean valid victim in set 4
    access(1'b0, 32'h80,  32'h0, stalls, base);
    access(1'b0, 32'h280, 32'h0, stalls, base);
    check("set4_fill_stalls", 32'(stalls), 32'd6);
    access(1'b0, 32'h480, 32'h0, stalls, base);
    check("clean_victim_stalls", 32'(stalls), 32'd6);
    check("clean_victim_nreq", 32'(mem_log.size() - base), 32'd1);
    if (mem_log.size() > base) check("clean_victim_wr", 32'(mem_log[base].wr), 32'd0);

    // Second way of set 2, memory acks in the entry cycle
    ack_delay = 1;
    access(1'b1, 32'h240, 32'hCAFE_0240, stalls, base);
    check("fast_ack_stalls", 32'(stalls), 32'd4);
    ack_delay = 3;

    // Third tag in set 2: dirty victim written back before refill
    access(1'b1, 32'h444, 32'h1111_0444, stalls, base);
    check("dirty_stalls", 32'(stalls), 32'd9);
    check("dirty_nreq", 32'(mem_log.size() - base), 32'd2);
    if (mem_log.size() > base + 1) begin
      check("wb_wr",    32'(mem_log[base].wr),         32'd1);
      check("wb_addr",  mem_log[base].addr,            32'h40);
      check("wb_word1", mem_log[base].data[63:32],     32'hDEAD_BEEF);
      check("wb_word0", mem_log[base].data[31:0],      init_word(32'h40));
      check("rf_wr",    32'(mem_log[base + 1].wr),     32'd0);
      check("rf_addr",  mem_log[base + 1].addr,        32'h440);
    end

    // Written-back data comes back through memory
    access(1'b0, 32'h44,  32'h0, stalls, base);
    check("reload_stalls", 32'(stalls), 32'd9);
    access(1'b0, 32'h240, 32'h0, stalls, base);
    access(1'b0, 32'h480, 32'h0, stalls, base);
    check("hit_stalls", 32'(stalls), 32'd0);

    // Reset while refilling
    mem_auto = 1'b0;
    @(posedge clk); #1;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h600;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("refill_mem_enable", 32'(bus.mem_enable_o), 32'd1);
    check("refill_mem_addr",   bus.mem_addr_o,        32'h600);
    check("refill_mem_write",  32'(bus.mem_write_o),  32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mem_enable", 32'(bus.mem_enable_o), 32'd0);
    check("midrst_stall",      32'(bus.cpu_stall_o),  32'd0);
    rst           = 1'b0;
    bus.cpu_req_i = 1'b0;
    man_ack       = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    check("late_ack_mem_enable", 32'(bus.mem_enable_o), 32'd0);
    check("late_ack_stall",      32'(bus.cpu_stall_o),  32'd0);
    mem_auto = 1'b1;
    access(1'b0, 32'h600, 32'h0, stalls, base);
    check("remiss_stalls", 32'(stalls), 32'd6);
    check("remiss_nreq", 32'(mem_log.size() - base), 32'd1);

    // Three plain hits after one miss
    access(1'b0, 32'h604, 32'h0, stalls, base);
    access(1'b1, 32'h608, 32'h1234_5678, stalls, base);
    access(1'b0, 32'h608, 32'h0, stalls, base);
    check("last_hit_stalls", 32'(stalls), 32'd0);
`ifdef DCACHE_PERF_CNT_EN
    check("miss_cnt", miss_cnt, 32'd1);
    check("hit_cnt",  hit_cnt,  32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
